retire_trace_unit: RTL and testbench

Captures one commit event per cycle from the MEM/WB boundary of the 5-stage pipeline and classifies it as register write, load, store, halt or no-write (branch/NOP). Each event is tagged with a running instruction number and buffered in a small FIFO. The FIFO drains through a valid/ready stream to an off-core trace sink. This gives hardware runs the same commit-level trace the simulation bench prints.

---
 rtl/retire_trace_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_retire_trace_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_unit.sv
// retire_trace_unit
//   Captures one commit event per cycle at the MEM/WB boundary and classifies
//   it (NOP/branch, REG, LOAD, STORE, HALT). Each event is tagged with a
//   running instruction number and queued in a small FIFO. The FIFO drains to
//   an off-core trace sink through a valid/ready stream.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   INUM_W  instruction-number width
//
// Build option
//   TRACE_FILTER_NOP_EN  when defined, NOP-kind events are never queued and
//                        never counted as drops. The instruction number still
//                        advances, so the trace shows the gaps.
//
// Ports
//   clk, rst_n         clock (rising edge) and async active-low reset
//   retire             one instruction commits this cycle
//   pc                 PC of the committing instruction
//   reg_wr/wr_reg/wr_data        register-file write of the commit
//   mem_rd/mem_wr/mem_addr/mem_data  memory access of the commit
//   hlt                committing instruction is HLT
//   tr_valid/tr_ready  trace stream handshake
//   tr_kind/tr_inum/tr_pc/tr_reg/tr_data/tr_addr  head packet fields
//   full               FIFO holds DEPTH entries
//   drop_cnt           events lost to a full FIFO, saturating at 255
//   done               HALT packet has left the FIFO
module retire_trace_unit #(
   parameter int DEPTH  = 8,
   parameter int INUM_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              retire,
   input  logic [15:0]       pc,
   input  logic              reg_wr,
   input  logic [3:0]        wr_reg,
   input  logic [15:0]       wr_data,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [15:0]       mem_addr,
   input  logic [15:0]       mem_data,
   input  logic              hlt,
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [2:0]        tr_kind,
   output logic [INUM_W-1:0] tr_inum,
   output logic [15:0]       tr_pc,
   output logic [3:0]        tr_reg,
   output logic [15:0]       tr_data,
   output logic [15:0]       tr_addr,
   output logic              full,
   output logic [7:0]        drop_cnt,
   output logic              done
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] KIND_NOP   = 3'd0;
   localparam logic [2:0] KIND_REG   = 3'd1;
   localparam logic [2:0] KIND_LOAD  = 3'd2;
   localparam logic [2:0] KIND_STORE = 3'd3;
   localparam logic [2:0] KIND_HALT  = 3'd4;

   localparam logic [AW:0]       COUNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]       COUNT_ZERO = (AW+1)'(0);
   localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
   localparam logic [INUM_W-1:0] INUM_ONE   = INUM_W'(1);

   typedef struct packed {
      logic [2:0]        kind;
      logic [INUM_W-1:0] inum;
      logic [15:0]       pc;
      logic [3:0]        rg;
      logic [15:0]       data;
      logic [15:0]       addr;
   } pkt_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   pkt_t              mem_q [DEPTH];
   pkt_t              mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [INUM_W-1:0] inum_q, inum_d;
   logic [7:0]        drop_q, drop_d;

   pkt_t pkt_s;
   pkt_t head_s;
   logic filt_s;
   logic in_run_s;
   logic fifo_full_s;
   logic pop_s;
   logic push_s;
   logic drop_s;

   // Classify the incoming commit; unused fields stay zero.
   always_comb begin
      pkt_s      = '0;
      pkt_s.inum = inum_q;
      pkt_s.pc   = pc;
      if (reg_wr && mem_rd) begin
         pkt_s.kind = KIND_LOAD;
         pkt_s.rg   = wr_reg;
         pkt_s.data = wr_data;
         pkt_s.addr = mem_addr;
      end else if (reg_wr) begin
         pkt_s.kind = KIND_REG;
         pkt_s.rg   = wr_reg;
         pkt_s.data = wr_data;
      end else if (hlt) begin
         pkt_s.kind = KIND_HALT;
      end else if (mem_wr) begin
         pkt_s.kind = KIND_STORE;
         pkt_s.data = mem_data;
         pkt_s.addr = mem_addr;
      end else begin
         pkt_s.kind = KIND_NOP;
      end
   end

`ifdef TRACE_FILTER_NOP_EN
   assign filt_s = (pkt_s.kind == KIND_NOP);
`else
   assign filt_s = 1'b0;
`endif

   assign head_s      = mem_q[rd_ptr_q];
   assign in_run_s    = (state_q == ST_RUN);
   assign fifo_full_s = (count_q == COUNT_FULL);
   assign pop_s       = (count_q != COUNT_ZERO) && tr_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_s      = retire && in_run_s && !filt_s && (!fifo_full_s || pop_s);
   assign drop_s      = retire && in_run_s && !filt_s && fifo_full_s && !pop_s;

   // Pointer, occupancy, instruction-number and drop-counter next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      inum_d   = inum_q;
      drop_d   = drop_q;
      count_d  = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      // Filtered and dropped commits still advance the number so gaps show.
      if (retire && in_run_s) begin
         inum_d = inum_q + INUM_ONE;
      end else begin
         inum_d = inum_q;
      end
      if (drop_s && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Storage next state: only the write-pointer slot changes on a push.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_s) begin
         mem_d[wr_ptr_q] = pkt_s;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
   end

   // Run/halted/done sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (push_s && (pkt_s.kind == KIND_HALT)) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALTED: begin
            // The HALT packet is the last one queued, so it is popped last.
            if (pop_s && (head_s.kind == KIND_HALT)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_HALTED;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers; reset also discards every buffered packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= COUNT_ZERO;
         inum_q   <= {INUM_W{1'b0}};
         drop_q   <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         inum_q   <= inum_d;
         drop_q   <= drop_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // All outputs come straight from registered state.
   assign tr_valid = (count_q != COUNT_ZERO);
   assign tr_kind  = head_s.kind;
   assign tr_inum  = head_s.inum;
   assign tr_pc    = head_s.pc;
   assign tr_reg   = head_s.rg;
   assign tr_data  = head_s.data;
   assign tr_addr  = head_s.addr;
   assign full     = fifo_full_s;
   assign drop_cnt = drop_q;
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_unit.sv
// Testbench for retire_trace_unit: table of classification vectors, directed
// multi-cycle sequences, then randomized traffic checked against a queue-based
// reference model of the trace unit.
module tb_retire_trace_unit;
   localparam int DEPTH = 8;
`ifdef TRACE_FILTER_NOP_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        retire = 1'b0;
   logic [15:0] pc = 16'h0;
   logic        reg_wr = 1'b0;
   logic [3:0]  wr_reg = 4'h0;
   logic [15:0] wr_data = 16'h0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [15:0] mem_addr = 16'h0;
   logic [15:0] mem_data = 16'h0;
   logic        hlt = 1'b0;
   logic        tr_valid;
   logic        tr_ready = 1'b0;
   logic [2:0]  tr_kind;
   logic [15:0] tr_inum;
   logic [15:0] tr_pc;
   logic [3:0]  tr_reg;
   logic [15:0] tr_data;
   logic [15:0] tr_addr;
   logic        full;
   logic [7:0]  drop_cnt;
   logic        done;

   always #5 clk = ~clk;

   retire_trace_unit #(.DEPTH(DEPTH), .INUM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc),
      .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
      .hlt(hlt), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
      .tr_inum(tr_inum), .tr_pc(tr_pc), .tr_reg(tr_reg), .tr_data(tr_data),
      .tr_addr(tr_addr), .full(full), .drop_cnt(drop_cnt), .done(done)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int          kind;
      int          inum;
      logic [15:0] pc;
      logic [3:0]  rg;
      logic [15:0] data;
      logic [15:0] addr;
   } mpkt_t;

   mpkt_t mq[$];
   int    mcnt;
   int    mdrop;
   int    mstate;   // 0 running, 1 halted, 2 done

   task automatic model_reset();
      mq.delete();
      mcnt = 0;
      mdrop = 0;
      mstate = 0;
   endtask

   task automatic model_step();
      bit    pop, push, drop, run, filt;
      mpkt_t p;
      pop = (mq.size() != 0) && tr_ready;
      p.pc = pc; p.inum = mcnt; p.rg = 4'h0; p.data = 16'h0; p.addr = 16'h0;
      if (reg_wr && mem_rd) begin p.kind = 2; p.rg = wr_reg; p.data = wr_data; p.addr = mem_addr; end
      else if (reg_wr)      begin p.kind = 1; p.rg = wr_reg; p.data = wr_data; end
      else if (hlt)         begin p.kind = 4; end
      else if (mem_wr)      begin p.kind = 3; p.data = mem_data; p.addr = mem_addr; end
      else                  begin p.kind = 0; end
      run  = (mstate == 0);
      filt = FILT && (p.kind == 0);
      push = retire && run && !filt && ((mq.size() < DEPTH) || pop);
      drop = retire && run && !filt && !push;
      if (pop) begin
         if (mq[0].kind == 4 && mstate == 1) mstate = 2;
         void'(mq.pop_front());
      end
      if (push) begin
         mq.push_back(p);
         if (p.kind == 4) mstate = 1;
      end
      if (retire && run) mcnt = (mcnt + 1) % 65536;
      if (drop && mdrop < 255) mdrop++;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("m_valid", 32'(tr_valid), 32'(mq.size() != 0));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(mdrop));
      chk("m_done", 32'(done), 32'(mstate == 2));
      if (mq.size() != 0) begin
         chk("m_kind", 32'(tr_kind), 32'(mq[0].kind));
         chk("m_inum", 32'(tr_inum), 32'(mq[0].inum));
         chk("m_pc",   32'(tr_pc),   32'(mq[0].pc));
         chk("m_reg",  32'(tr_reg),  32'(mq[0].rg));
         chk("m_data", 32'(tr_data), 32'(mq[0].data));
         chk("m_addr", 32'(tr_addr), 32'(mq[0].addr));
      end
   endtask

   // One clock: advance the model with the applied inputs, then compare.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic set_in(input logic r, input logic rw, input logic mr, input logic mw,
                         input logic h, input logic [3:0] wreg, input logic [15:0] wdata,
                         input logic [15:0] maddr, input logic [15:0] mdata, input logic [15:0] pcv);
      retire = r; reg_wr = rw; mem_rd = mr; mem_wr = mw; hlt = h;
      wr_reg = wreg; wr_data = wdata; mem_addr = maddr; mem_data = mdata; pc = pcv;
   endtask

   task automatic retire_reg(input logic [3:0] r);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r, {12'h0, r}, 16'h0, 16'h0, 16'h0100);
   endtask

   task automatic idle_in();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_in();
      tr_ready = 1'b0;
      #2;
      model_reset();
      chk("rst_valid", 32'(tr_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_kind", 32'(tr_kind), 32'd0);
      chk("rst_inum", 32'(tr_inum), 32'd0);
      chk("rst_pc", 32'(tr_pc), 32'd0);
      chk("rst_reg", 32'(tr_reg), 32'd0);
      chk("rst_data", 32'(tr_data), 32'd0);
      chk("rst_addr", 32'(tr_addr), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- classification table ----------------
   typedef struct {
      logic rw, mr, mw, h;
      logic [3:0]  wreg;
      logic [15:0] wdata, maddr, mdata, pcv;
      logic [2:0]  ekind;
      logic [3:0]  ereg;
      logic [15:0] edata, eaddr;
   } vec_t;

   vec_t tbl[7];
   int   bias;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 3'd1, 4'd3, 16'h0005, 16'h0000};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 16'h1234, 16'h0010, 16'h5555, 16'h0002, 3'd2, 4'd7, 16'h1234, 16'h0010};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 16'h7777, 16'h0012, 16'hBEEF, 16'h0004, 3'd3, 4'd0, 16'hBEEF, 16'h0012};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 16'h1111, 16'h2222, 16'h3333, 16'h0006, 3'd0, 4'd0, 16'h0000, 16'h0000};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 16'hABCD, 16'h0040, 16'h9999, 16'h0008, 3'd1, 4'd2, 16'hABCD, 16'h0000};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0042, 16'h0050, 16'h0000, 16'h000A, 3'd1, 4'd1, 16'h0042, 16'h0000};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 16'h1111, 16'h0060, 16'h2222, 16'h000C, 3'd4, 4'd0, 16'h0000, 16'h0000};

      #1;
      do_reset();

      // Table: one commit, check the packet one cycle later, then it drains.
      tr_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_in(1'b1, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].h, tbl[i].wreg,
                tbl[i].wdata, tbl[i].maddr, tbl[i].mdata, tbl[i].pcv);
         cycle();
         if (FILT && tbl[i].ekind == 3'd0) begin
            chk("t_filtered", 32'(tr_valid), 32'd0);
         end else begin
            chk("t_valid", 32'(tr_valid), 32'd1);
            chk("t_kind", 32'(tr_kind), 32'(tbl[i].ekind));
            chk("t_inum", 32'(tr_inum), 32'(i));
            chk("t_pc", 32'(tr_pc), 32'(tbl[i].pcv));
            chk("t_reg", 32'(tr_reg), 32'(tbl[i].ereg));
            chk("t_data", 32'(tr_data), 32'(tbl[i].edata));
            chk("t_addr", 32'(tr_addr), 32'(tbl[i].eaddr));
         end
         idle_in();
         cycle();
         chk("t_drained", 32'(tr_valid), 32'd0);
      end
      chk("t_done_after_halt", 32'(done), 32'd1);

      // Overflow: 10 commits into a stalled FIFO, then drain.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         retire_reg(4'(i));
         cycle();
         if (i == 7) chk("ovf_full_at_8", 32'(full), 32'd1);
      end
      chk("ovf_drop2", 32'(drop_cnt), 32'd2);
      idle_in();
      tr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain_inum", 32'(tr_inum), 32'(i));
         cycle();
      end
      chk("ovf_empty", 32'(tr_valid), 32'd0);
      tr_ready = 1'b0;
      retire_reg(4'd1);
      cycle();
      chk("ovf_next_inum10", 32'(tr_inum), 32'd10);

      // Full FIFO with simultaneous push/pop: no drops, stays full.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         retire_reg(4'(i));
         cycle();
      end
      chk("pp_full", 32'(full), 32'd1);
      tr_ready = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         retire_reg(4'(k));
         cycle();
         chk("pp_full_held", 32'(full), 32'd1);
         chk("pp_no_drop", 32'(drop_cnt), 32'd0);
         chk("pp_head_inum", 32'(tr_inum), 32'(k));
      end

      // HALT at inum 4 followed by ignored commits.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         retire_reg(4'(i));
         cycle();
      end
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0200);
      cycle();
      for (int i = 0; i < 3; i++) begin
         retire_reg(4'(i));
         cycle();
      end
      idle_in();
      chk("h_five_queued", 32'(full), 32'd0);
      tr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("h_inum", 32'(tr_inum), 32'(i));
         chk("h_not_done", 32'(done), 32'd0);
         cycle();
      end
      chk("h_empty", 32'(tr_valid), 32'd0);
      chk("h_done", 32'(done), 32'd1);
      retire_reg(4'd9);
      cycle();
      chk("h_idle_after_done", 32'(tr_valid), 32'd0);

      // Mid-stream reset discards buffered packets and restarts numbering.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         retire_reg(4'(i));
         cycle();
      end
      do_reset();
      retire_reg(4'd6);
      cycle();
      chk("mr_inum0", 32'(tr_inum), 32'd0);

      // Drop counter saturates.
      do_reset();
      for (int i = 0; i < 270; i++) begin
         retire_reg(4'(i));
         cycle();
      end
      chk("sat_255", 32'(drop_cnt), 32'd255);

`ifdef TRACE_FILTER_NOP_EN
      // REG, NOP, REG: only inums 0 and 2 are queued.
      do_reset();
      retire_reg(4'd1);
      cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      cycle();
      retire_reg(4'd2);
      cycle();
      idle_in();
      chk("f_head0", 32'(tr_inum), 32'd0);
      tr_ready = 1'b1;
      cycle();
      chk("f_head2", 32'(tr_inum), 32'd2);
      chk("f_nodrop", 32'(drop_cnt), 32'd0);
      cycle();
      chk("f_empty", 32'(tr_valid), 32'd0);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      bias = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 64 == 0) begin
            case ($urandom_range(0, 2))
               0: bias = 10;
               1: bias = 50;
               default: bias = 95;
            endcase
         end
         if ((mstate == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 599) == 0) begin
            do_reset();
         end
         retire   = ($urandom_range(0, 3) != 0);
         reg_wr   = 1'($urandom_range(0, 1));
         mem_rd   = 1'($urandom_range(0, 1));
         mem_wr   = 1'($urandom_range(0, 1));
         hlt      = ($urandom_range(0, 40) == 0);
         wr_reg   = 4'($urandom);
         wr_data  = 16'($urandom);
         mem_addr = 16'($urandom);
         mem_data = 16'($urandom);
         pc       = 16'($urandom);
         tr_ready = ($urandom_range(0, 99) < bias);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
